// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if: request/grant bundle between requesters and the round-robin mux-select arbiter.
interface mux_sel_arbiter_if #(
  parameter int NB_SEL = 2,
  parameter int NB_REQ = 4
);
  logic [NB_REQ-1:0] i_req;
  logic              i_done;
  logic [NB_REQ-1:0] o_grant;
  logic [NB_SEL-1:0] o_sel;
  logic              o_busy;
  logic              o_timeout;
  modport master (output i_req, i_done, input o_grant, o_sel, o_busy, o_timeout);
  modport slave  (input i_req, i_done, output o_grant, o_sel, o_busy, o_timeout);
endinterface

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter driving a 4:1 mux select, grant held until done, withdraw or hold-timeout.
module mux_sel_arbiter #(
  parameter int NB_SEL   = 2,
  parameter int NB_REQ   = 4,
  parameter int MAX_HOLD = 16,
  parameter int NB_HOLD  = 5
) (
  input logic               i_clk,
  input logic               i_rst,
  mux_sel_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t              r_state;
  logic [NB_SEL-1:0]   r_ptr;
  logic [NB_HOLD-1:0]  r_cnt;
  logic [NB_REQ-1:0]   r_grant;
  logic [NB_SEL-1:0]   r_sel;
  logic                r_busy;
  logic                r_timeout;
  logic [NB_SEL-1:0]   w_win;
  logic                w_last;
  logic                w_release;
  // Scan from lowest priority to highest so the last hit is the first requester after ptr.
  always_comb begin
    w_win = r_ptr;
    for (int k = NB_REQ - 1; k >= 0; k--)
      if (bus.i_req[r_ptr + NB_SEL'(k)]) w_win = r_ptr + NB_SEL'(k);
  end
  assign w_last    = r_cnt == NB_HOLD'(MAX_HOLD - 1);
  assign w_release = bus.i_done || !bus.i_req[r_sel] || w_last;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_sel     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (r_state == IDLE) begin
        if (|bus.i_req) begin
          r_state <= GRANT;
          r_grant <= NB_REQ'(1) << w_win;
          r_sel   <= w_win;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
      end else if (w_release) begin
        r_state   <= IDLE;
        r_grant   <= '0;
        r_busy    <= 1'b0;
        r_ptr     <= r_sel + NB_SEL'(1);
        r_timeout <= !bus.i_done && bus.i_req[r_sel];
      end else begin
        r_cnt <= r_cnt + NB_HOLD'(1);
      end
    end
  end
  assign bus.o_grant   = r_grant;
  assign bus.o_sel     = r_sel;
  assign bus.o_busy    = r_busy;
  assign bus.o_timeout = r_timeout;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed vector table plus hand sequences for timeout, coincident events and async reset.
module tb_mux_sel_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  mux_sel_arbiter_if #(.NB_SEL(2), .NB_REQ(4)) bus ();
  mux_sel_arbiter #(.NB_SEL(2), .NB_REQ(4), .MAX_HOLD(16), .NB_HOLD(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } vec_t;
  vec_t vt[33];
  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                       input logic eb, input logic et);
    n_tests++;
    if (bus.o_grant !== eg || bus.o_sel !== es || bus.o_busy !== eb || bus.o_timeout !== et) begin
      n_fail++;
      $display("FAIL %s: got grant=%b sel=%0d busy=%b timeout=%b, want grant=%b sel=%0d busy=%b timeout=%b",
               name, bus.o_grant, bus.o_sel, bus.o_busy, bus.o_timeout, eg, es, eb, et);
    end
  endtask
  task automatic step(input logic [3:0] req, input logic done);
    bus.i_req  = req;
    bus.i_done = done;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vt[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vt[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vt[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[9]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[10] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[11] = '{4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vt[12] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[13] = '{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[14] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[15] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[16] = '{4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0};
    vt[17] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[18] = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[19] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[20] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[21] = '{4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[22] = '{4'b1101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[23] = '{4'b1101, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vt[24] = '{4'b1101, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0};
    vt[25] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vt[26] = '{4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0};
    vt[27] = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vt[28] = '{4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[29] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[30] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vt[31] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vt[32] = '{4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    bus.i_req  = '0;
    bus.i_done = 1'b0;
    #1;
    check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #3;
    for (int i = 0; i < 33; i++) begin
      step(vt[i].req, vt[i].done);
      check($sformatf("vec%0d", i), vt[i].grant, vt[i].sel, vt[i].busy, vt[i].to);
    end
    // ptr=2: requester 2 held with no done must time out after exactly 16 grant cycles.
    for (int i = 1; i <= 16; i++) begin
      step(4'b0100, 1'b0);
      check($sformatf("hold_c%0d", i), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(4'b0100, 1'b0);
    check("timeout_release", 4'b0000, 2'd2, 1'b0, 1'b1);
    step(4'b0000, 1'b0);
    check("timeout_pulse_end", 4'b0000, 2'd2, 1'b0, 1'b0);
    // ptr=3: done coincident with the last hold cycle is a normal release.
    for (int i = 1; i <= 16; i++) begin
      step(4'b1000, 1'b0);
      check($sformatf("coinc_c%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    step(4'b1000, 1'b1);
    check("done_with_timeout", 4'b0000, 2'd3, 1'b0, 1'b0);
    step(4'b1111, 1'b0);
    check("wrap_after_coinc", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1111, 1'b1);
    check("rst_seq_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 1'b0);
    check("rst_seq_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_reset_midgrant", 4'b0000, 2'd0, 1'b0, 1'b0);
    #3 rst = 1'b0;
    step(4'b1111, 1'b0);
    check("post_reset_grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1111, 1'b1);
    check("post_reset_release", 4'b0000, 2'd0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_sel_arbiter.md
# mux_sel_arbiter

Round-robin arbiter that shares one 4-input datapath resource among four requesters by driving the 2-bit select of a 4-to-1 multiplexer. Typical uses are the shared memory/register-read path and the debug-unit access path of the MIPS datapath. The block grants one requester at a time and holds the grant until the resource signals completion, the requester withdraws, or a hold-timeout expires. It then rotates priority so that every requester is served within four grants.

## Interface
- `NB_SEL`, default 2: width of the mux select. Fixed at 2, giving 4 requesters.
- `NB_REQ`, default 4: number of requesters. Must equal 2**NB_SEL.
- `MAX_HOLD`, default 16: maximum number of cycles a grant may be held before forced release. Legal range is 2..2**NB_HOLD.
- `NB_HOLD`, default 5: width of the hold counter.

Clocking and reset:
- One clock: `i_clk`.
- Reset is asynchronous and active-high: `i_rst`.

Ports:
- `i_clk`, input, 1: clock. All state updates occur on the rising edge.
- `i_rst`, input, 1: asynchronous active-high reset.
- `i_req`, input, NB_REQ: request lines. Bit k belongs to requester k, which drives mux input k (a=0, b=1, c=2, d=3).
- `i_done`, input, 1: resource completion strobe, one cycle wide. Only meaningful while `o_busy`=1.
- `o_grant`, output, NB_REQ: one-hot grant, registered.
- `o_sel`, output, NB_SEL: mux select, equal to the encoded index of the current or most recent winner, registered.
- `o_busy`, output, 1: high while a grant is active.
- `o_timeout`, output, 1: one-cycle pulse when a grant is force-released by timeout.

## Operation
- State machine with two states, IDLE and GRANT. Reset enters IDLE.
- Internal state:
  - Priority pointer `ptr` (NB_SEL bits): the index of the highest-priority requester.
  - Hold counter `cnt` (NB_HOLD bits).
- IDLE:
  - If `i_req`≠0, the winner w is the first index k in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with `i_req[k]`=1.
  - On the next edge: `o_grant` = one-hot(w), `o_sel` = w, `o_busy` = 1, `cnt` = 0, and the state becomes GRANT.
  - If `i_req`=0, the block stays in IDLE and all outputs hold.
- GRANT, winner w. Release conditions, evaluated every cycle in this priority order:
  1. `i_done`=1 → normal release.
  2. `i_req[w]`=0 → withdraw release.
  3. `cnt`=MAX_HOLD-1 → timeout release; `o_timeout` pulses for 1 cycle.
  4. Otherwise `cnt` increments by 1.
- On any release, at the next edge:
  - `o_grant`=0 and `o_busy`=0.
  - `ptr` = (w+1) mod 4. Wrap-around from 3 to 0 is required.
  - State becomes IDLE.
  - `o_sel` keeps value w, so the mux output stays stable.
- Requests from other requesters during GRANT are ignored until the next arbitration in IDLE. There is no preemption.
- `i_done` while in IDLE is ignored, with no state change.
- Simultaneous `i_done` and the timeout condition: treated as a normal release, and `o_timeout` stays 0.
- Simultaneous `i_done` and withdraw of `i_req[w]`: normal release, with identical effect.
- `cnt` saturates at MAX_HOLD-1. It never wraps.

## Timing
- Reset values, applied asynchronously:
  - `o_grant`=4'b0000, `o_sel`=2'b00, `o_busy`=0, `o_timeout`=0.
  - `ptr`=0, `cnt`=0, state IDLE.
- Reset asserted mid-grant: all outputs go to their reset values immediately, without waiting for a clock edge. After deassertion, arbitration restarts with `ptr`=0.
- Request to grant latency: 1 cycle. A request seen at edge n in IDLE produces `o_grant` valid after edge n.
- Release latency: 1 cycle after the sampled release condition.
- Arbitration bubble: at least 1 IDLE cycle between consecutive grants. The maximum back-to-back rate is therefore 1 grant every 2 cycles for single-cycle transactions.
- Maximum grant length is MAX_HOLD cycles. `o_timeout` asserts on the same edge on which `o_grant` clears.
- Starvation bound: a continuously asserted request is granted within 3 other grants plus 4 bubbles.

## Test plan
- Reset: assert `i_rst` mid-grant with `i_req`=4'b1111 → `o_grant`=0000, `o_sel`=00, `o_busy`=0 without a clock edge; after release, the first grant goes to requester 0.
- Round-robin rotation: hold `i_req`=4'b1111 and pulse `i_done` on the first cycle of each grant → the grant sequence is 0,1,2,3,0, and `o_sel` follows it as 00,01,10,11,00, with one idle cycle between grants.
- Pointer wrap with sparse requests: requester 3 is served (`ptr`=0 after wrap), then `i_req`=4'b1001 → grant goes to 0; on the next arbitration with `i_req`=4'b1001 → grant goes to 3.
- Timeout: MAX_HOLD=16, `i_req`=4'b0100 held, no `i_done` → `o_grant`=0100 for exactly 16 cycles, then `o_timeout`=1 for 1 cycle, `o_busy`=0, and `o_sel` stays 10.
- Simultaneous events: `i_done` coincident with `cnt`=MAX_HOLD-1 → release with `o_timeout`=0. A separate check: drop `i_req[w]` mid-grant → release on the next edge and `ptr`=w+1.
- No preemption: requester 2 is granted, then `i_req[0]` rises → `o_grant` stays 0100 until `i_done`; the next grant goes to 0 only if requester 3 is not requesting (`ptr`=3 means requester 3 has priority).
